// File: rtl/sign_extd8.sv
//------------------------------------------------------------------------------
// Module   : sign_extd8
// Purpose  : Sign/zero extender with a combinational result and a registered
//            valid/ready output stage backed by a one-entry skid buffer.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sign_extd8 #(
  parameter int IN_W  = 4,
  parameter int OUT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IN_W-1:0]  data_in,
  input  logic             zext,
  output logic [OUT_W-1:0] comb_out,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] data_out
);

  localparam int c_padW = OUT_W - IN_W;

  if (IN_W < 1 || OUT_W <= IN_W) begin : g_paramCheck
    $error("sign_extd8: requires IN_W >= 1 and OUT_W > IN_W");
  end

  logic [OUT_W-1:0] w_ext;
  logic             w_inXfer;
  logic             w_outXfer;

  logic [OUT_W-1:0] r_mainData;
  logic             r_mainValid;
  logic [OUT_W-1:0] r_skidData;
  logic             r_skidFull;

  always_comb begin
    w_ext = zext ? {{c_padW{1'b0}}, data_in}
                 : {{c_padW{data_in[IN_W-1]}}, data_in};
  end

  assign comb_out  = w_ext;
  assign in_ready  = ~r_skidFull;
  assign out_valid = r_mainValid;
  assign data_out  = r_mainData;

  assign w_inXfer  = in_valid & ~r_skidFull;
  assign w_outXfer = r_mainValid & out_ready;

  // The skid never accepts while full, so a skid-to-main refill and a new
  // capture cannot collide; data regs load only on a real transfer so X on an
  // idle data_in never reaches storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mainData  <= '0;
      r_mainValid <= 1'b0;
      r_skidData  <= '0;
      r_skidFull  <= 1'b0;
    end else if (w_outXfer && r_skidFull) begin
      r_mainData  <= r_skidData;
      r_mainValid <= 1'b1;
      r_skidFull  <= 1'b0;
    end else if (w_inXfer) begin
      if (!r_mainValid || w_outXfer) begin
        r_mainData  <= w_ext;
        r_mainValid <= 1'b1;
      end else begin
        r_skidData  <= w_ext;
        r_skidFull  <= 1'b1;
      end
    end else if (w_outXfer) begin
      r_mainValid <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sign_extd8.sv
//------------------------------------------------------------------------------
// Module   : tb_sign_extd8
// Purpose  : Directed scoreboard bench for sign_extd8 (default and 8->16 build).
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_sign_extd8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] data_in;
  logic       zext;
  logic [7:0] comb_out;
  logic       in_valid;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] data_out;

  logic [7:0]  dataIn16;
  logic        zext16;
  logic [15:0] combOut16;
  logic        inValid16;
  logic        inReady16;
  logic        outValid16;
  logic        outReady16;
  logic [15:0] dataOut16;

  int nAsserts = 0;
  int nFails   = 0;
  logic [7:0] q[$];

  always #5 clk = ~clk;

  sign_extd8 dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .zext(zext),
    .comb_out(comb_out), .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out)
  );

  sign_extd8 #(.IN_W(8), .OUT_W(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .data_in(dataIn16), .zext(zext16),
    .comb_out(combOut16), .in_valid(inValid16), .in_ready(inReady16),
    .out_valid(outValid16), .out_ready(outReady16), .data_out(dataOut16)
  );

  function automatic logic [7:0] expExt(input logic [3:0] d, input logic z);
    return z ? {4'h0, d} : 8'($signed(d));
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkState(input string tag);
    chk({tag, ".in_ready"}, 16'(in_ready), 16'(q.size() < 2));
    chk({tag, ".out_valid"}, 16'(out_valid), 16'(q.size() > 0));
    if (q.size() > 0) chk({tag, ".data_out"}, 16'(data_out), 16'(q[0]));
  endtask

  // One clock: model pops/pushes on the edge, outputs sampled 1ns after.
  task automatic step(input string tag);
    bit pop, push;
    logic [7:0] e;
    pop  = (q.size() > 0) && out_ready;
    push = in_valid && (q.size() < 2);
    e    = expExt(data_in, zext);
    @(posedge clk);
    if (pop)  void'(q.pop_front());
    if (push) q.push_back(e);
    #1;
    checkState(tag);
  endtask

  logic [3:0] sweepIn  [8] = '{4'h0, 4'h1, 4'hE, 4'h3, 4'h8, 4'h7, 4'hA, 4'hF};
  logic [7:0] sweepExp [8] = '{8'h00, 8'h01, 8'hFE, 8'h03, 8'hF8, 8'h07, 8'hFA, 8'hFF};
  logic [3:0] zIn  [3] = '{4'hE, 4'h8, 4'hF};
  logic [7:0] zExp [3] = '{8'h0E, 8'h08, 8'h0F};

  initial begin
    rst_n = 1'b0; data_in = 4'h0; zext = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    dataIn16 = 8'h00; zext16 = 1'b0; inValid16 = 1'b0; outReady16 = 1'b0;
    #1;
    chk("rst.out_valid", 16'(out_valid), 16'h0);
    chk("rst.data_out", 16'(data_out), 16'h00);
    chk("rst.in_ready", 16'(in_ready), 16'h1);

    for (int i = 0; i < 8; i++) begin
      data_in = sweepIn[i]; #1;
      chk("comb.sext", 16'(comb_out), 16'(sweepExp[i]));
    end
    zext = 1'b1;
    for (int i = 0; i < 3; i++) begin
      data_in = zIn[i]; #1;
      chk("comb.zext", 16'(comb_out), 16'(zExp[i]));
    end
    zext = 1'b0;

    @(negedge clk); rst_n = 1'b1;
    data_in = 'x; in_valid = 1'b0;
    step("xidle");
    chk("xidle.data_out", 16'(data_out), 16'h00);

    // Zero-extend through the registered path.
    zext = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      data_in = zIn[i];
      step("zstream");
      chk("zstream.const", 16'(data_out), 16'(zExp[i]));
    end
    in_valid = 1'b0; step("zdrain");
    zext = 1'b0;

    // Full-rate streaming.
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      data_in = sweepIn[i];
      step("stream");
      chk("stream.const", 16'(data_out), 16'(sweepExp[i]));
      chk("stream.in_ready", 16'(in_ready), 16'h1);
    end
    in_valid = 1'b0; step("sdrain");

    // Backpressure: fill both entries, offer a third, then release.
    out_ready = 1'b0; in_valid = 1'b1;
    data_in = 4'h8; step("bp.push8");
    data_in = 4'h7; step("bp.push7");
    chk("bp.full_ready", 16'(in_ready), 16'h0);
    data_in = 4'hA; step("bp.offerA"); step("bp.offerA2");
    chk("bp.hold", 16'(data_out), 16'hF8);
    chk("bp.hold_valid", 16'(out_valid), 16'h1);
    out_ready = 1'b1;
    step("bp.drain1");
    chk("bp.order07", 16'(data_out), 16'h07);
    step("bp.drain2");
    chk("bp.orderFA", 16'(data_out), 16'hFA);
    in_valid = 1'b0;
    step("bp.drain3"); step("bp.drain4");

    // Async reset with two words stored.
    out_ready = 1'b0; in_valid = 1'b1;
    data_in = 4'h3; step("ar.push1");
    data_in = 4'hE; step("ar.push2");
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    q.delete();
    chk("ar.out_valid", 16'(out_valid), 16'h0);
    chk("ar.data_out", 16'(data_out), 16'h00);
    chk("ar.in_ready", 16'(in_ready), 16'h1);
    data_in = 4'h9; #1;
    chk("ar.comb", 16'(comb_out), 16'hF9);
    @(negedge clk); rst_n = 1'b1;
    in_valid = 1'b1; out_ready = 1'b1; data_in = 4'h5;
    step("ar.first");
    chk("ar.first_const", 16'(data_out), 16'h05);
    in_valid = 1'b0; step("ar.drain");

    // 8 -> 16 build.
    dataIn16 = 8'h80; zext16 = 1'b0; #1;
    chk("w16.sext80", combOut16, 16'hFF80);
    dataIn16 = 8'h7F; #1;
    chk("w16.sext7F", combOut16, 16'h007F);
    dataIn16 = 8'h80; zext16 = 1'b1; #1;
    chk("w16.zext80", combOut16, 16'h0080);
    zext16 = 1'b0; inValid16 = 1'b1; outReady16 = 1'b1;
    @(posedge clk); #1;
    chk("w16.reg", dataOut16, 16'hFF80);
    chk("w16.valid", 16'(outValid16), 16'h1);
    inValid16 = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sign_extd8.md
Name: sign_extd8

Overview:
- Sign extender for the pipelined CPU datapath: widens an IN_W-bit immediate/offset to OUT_W bits by replicating the MSB (default 4 -> 8).
- Provides a zero-latency combinational result (comb_out) for in-stage use.
- Provides a registered result (data_out) behind a valid/ready stage with a 1-entry skid buffer, for use across pipeline boundaries.
- Optional zero-extend mode per transfer.

Parameters:
- IN_W, 4, input field width; must be >= 1.
- OUT_W, 8, output width; must be > IN_W. Elaboration error otherwise.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- data_in  input  IN_W  value to extend.
- zext  input  1  1 = zero-extend, 0 = sign-extend; sampled with data_in.
- comb_out  output  OUT_W  combinational extension of data_in/zext.
- in_valid  input  1  data_in/zext valid this cycle.
- in_ready  output  1  stage can accept; registered.
- out_valid  output  1  data_out valid.
- out_ready  input  1  downstream accepts data_out.
- data_out  output  OUT_W  registered extended value.

Behaviour:
- Extension function ext(d,z):
  - Bits [IN_W-1:0] = d.
  - Bits [OUT_W-1:IN_W] = all d[IN_W-1] when z=0, all 0 when z=1.
  - Pure bit replication; no arithmetic, no saturation.
- comb_out = ext(data_in, zext):
  - Combinational, zero latency.
  - Independent of clk, rst_n, valid/ready.
  - Updates within the same delta/cycle as data_in.
- Handshake:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
  - data_out and out_valid are held stable while out_valid && !out_ready.
- Storage: main register (data_out/out_valid) plus one skid register (skid_data, skid_full).
  - Accepted word goes to the main register if it is empty or draining this cycle; otherwise it goes to the skid register.
  - On an output transfer with skid_full=1, skid_data moves to the main register and skid_full clears. A simultaneous input transfer is then impossible because in_ready=0.
  - in_ready = !skid_full. It is a registered signal: the skid_full flop drives it directly, with no combinational path from out_ready.
- Latency: accepted word appears on data_out the cycle after acceptance when the stage is empty.
- Throughput: 1 word/cycle with out_ready held high. Order is preserved (FIFO, depth 2).
- Simultaneous accept and drain with an empty skid: the new word replaces the main register and out_valid stays 1.
- Extension is computed at acceptance. Stored words are already extended; a later zext change does not affect them.
- Reset (rst_n low, asynchronous):
  - out_valid=0, data_out=0, skid_full=0, skid_data=0, in_ready=1.
  - Reset mid-transfer discards both stored words.
  - comb_out is unaffected by reset.
- After rst_n deasserts, the first rising edge can accept.
- in_valid while in_ready=0: ignored; the word is not captured and the upstream must hold it.
- X on data_in with in_valid=0 must not propagate into registers.

Test Plan:
- Combinational sweep with zext=0: data_in 0,1,E,3,8,7,A,F -> comb_out 00,01,FE,03,F8,07,FA,FF, with no clock needed.
- Zero-extend: zext=1, data_in E,8,F -> comb_out 0E,08,0F. With in_valid, data_out shows the same one cycle later.
- Streaming: out_ready=1, in_valid=1 for 8 cycles with data 0,1,E,3,8,7,A,F.
  - data_out = 00,01,FE,03,F8,07,FA,FF on consecutive cycles, each 1 cycle after its input.
  - in_ready is constantly 1.
- Backpressure: out_ready=0, push 8 then 7.
  - data_out=F8 holds with out_valid=1.
  - in_ready drops to 0 after the second accept; a third word (A) offered is not taken.
  - Raise out_ready: F8, 07, then FA (after re-offer) in order, with no loss or duplication.
- Async reset mid-operation: with two words stored, pulse rst_n low between clock edges.
  - out_valid=0, data_out=00, in_ready=1 immediately, without waiting for a clock edge.
  - comb_out still tracks data_in.
- Parameter variant IN_W=8, OUT_W=16: data_in 80 -> FF80; data_in 7F -> 007F; 80 with zext=1 -> 0080.
